evaluate_taper: RTL and testbench
=================================

Name: evaluate_taper

Overview:
- Downstream consumer of the per-term evaluators (killer, material, mobility, ...), each of which emits a signed eval_mg/eval_eg pair plus a level eval_valid at its own latency.
- Waits until every evaluator is valid, then accumulates the mg and eg terms sequentially.
- Blends the two sums by game phase into one saturated signed score.
- Presents the score with a level valid that holds until clear_eval.

Parameters:
- EVAL_WIDTH, 24, width of each input term and of the output score (signed).
- NUM_EVAL, 4, number of upstream evaluators (≥1).
- NUM_EVAL_LOG2, 2, index counter width (≥1; ≥ clog2(NUM_EVAL)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- board_valid  in  1  new board presented; the rising edge starts a collection.
- clear_eval  in  1  abort/retire the current evaluation.
- phase  in  9  game phase weight, 0 (endgame) to 256 (midgame); values above 256 are clamped to 256.
- eval_valid_in  in  NUM_EVAL  per-evaluator level valid.
- eval_mg_in  in  NUM_EVAL*EVAL_WIDTH  packed signed mg terms; evaluator i is at bits [i*EVAL_WIDTH +: EVAL_WIDTH].
- eval_eg_in  in  NUM_EVAL*EVAL_WIDTH  packed signed eg terms, same packing.
- eval  out  EVAL_WIDTH  signed tapered score.
- eval_valid  out  1  eval is final; level.

Behaviour:
- Reset (reset=0, async): state=IDLE; eval=0; eval_valid=0; all flags, latches, accumulators and counter cleared.
- Internal widths: accumulators are EVAL_WIDTH+NUM_EVAL_LOG2+1 bits; the product stage is accumulator width+10 bits.
- States: IDLE, COLLECT, SUM, TAPER, SAT, DONE.
- IDLE: on a board_valid rising edge (board_valid=1, previous sample 0):
  - register the clamped phase;
  - clear the per-evaluator captured flags;
  - go to COLLECT.
- COLLECT: each cycle, for every i with eval_valid_in[i]=1 and flag[i]=0:
  - latch mg[i] and eg[i];
  - set flag[i].
  - Later deassertion of eval_valid_in[i] does not clear its flag or latched terms.
  - When all flags are 1: acc_mg=0, acc_eg=0, idx=0, go to SUM.
- SUM: one term per cycle: acc_mg+=mg[idx], acc_eg+=eg[idx], idx++. After idx=NUM_EVAL-1 is added, go to TAPER.
- TAPER: prod = acc_mg*phase + acc_eg*(256-phase), registered; go to SAT.
- SAT: t = prod >>> 8 (arithmetic shift, floor toward -inf).
  - Clamp t to [-(2^(EVAL_WIDTH-1)-1), 2^(EVAL_WIDTH-1)-1] (symmetric, so negation is always safe).
  - eval <= t; eval_valid <= 1; go to DONE.
- DONE: hold eval and eval_valid=1. board_valid edges are ignored.
- Latency: let E0 be the clock edge at which the last outstanding eval_valid_in is captured. eval_valid rises at edge E0+NUM_EVAL+3.
  - If all inputs are already valid on the first COLLECT cycle, E0 is that cycle's edge.
- clear_eval=1 in any state:
  - next edge: state=IDLE, eval_valid=0, flags cleared.
  - eval retains its last value.
  - clear_eval has priority over a simultaneous board_valid edge; that edge is lost, and a new rising edge is needed after the clear.
- A board_valid rising edge outside IDLE (without clear) is ignored.
- The board_valid edge detector runs in every state, so a level held high across a clear does not retrigger.
- An async reset mid-operation returns everything to the reset values immediately.

Test Plan:
- NUM_EVAL=4, EVAL_WIDTH=24; mg={100,200,-50,0}, eg={10,20,30,40}; all valid together.
  - phase=256 -> eval=250.
  - phase=0 -> eval=100.
  - phase=128 -> eval=175.
  - Check eval_valid rises exactly 7 edges after capture.
- Staggered valids: evaluator 3 valid 10 cycles after the others, and evaluator 0 drops valid before the end -> the sum is unaffected. eval_valid rises 7 edges after evaluator 3 is captured.
- Rounding: single evaluator set to mg=1, eg=0, others 0, phase=128 -> eval=0. With mg=-1 -> eval=-1.
- Saturation: EVAL_WIDTH=12, all mg=2000, phase=256 -> eval=2047. All mg=-2000 -> eval=-2047.
- Clear mid-operation:
  - clear_eval during SUM -> eval_valid stays 0 and the state returns to IDLE. A fresh board_valid edge then yields the correct score.
  - clear_eval and board_valid rising on the same cycle -> no collection starts.
- Async reset asserted in TAPER -> eval=0 and eval_valid=0 immediately. After release, the first board_valid edge runs a full evaluation correctly.

Source files
------------

// File: rtl/evaluate_taper.sv
// Collects one signed mg/eg pair from each upstream evaluator and sums the pairs.
// The two sums are blended by game phase into one saturated score that holds until clear_eval.
module evaluate_taper #(
  parameter int EVAL_WIDTH    = 24,
  parameter int NUM_EVAL      = 4,
  parameter int NUM_EVAL_LOG2 = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           board_valid,
  input  logic                           clear_eval,
  input  logic [8:0]                     phase,
  input  logic [NUM_EVAL-1:0]            eval_valid_in,
  input  logic [NUM_EVAL*EVAL_WIDTH-1:0] eval_mg_in,
  input  logic [NUM_EVAL*EVAL_WIDTH-1:0] eval_eg_in,
  output logic [EVAL_WIDTH-1:0]          eval,
  output logic                           eval_valid
);

  localparam int ACC_W  = EVAL_WIDTH + NUM_EVAL_LOG2 + 1;
  localparam int PROD_W = ACC_W + 10;

  localparam logic [NUM_EVAL_LOG2-1:0] IDX_LAST = NUM_EVAL_LOG2'(NUM_EVAL - 1);
  localparam logic [NUM_EVAL_LOG2-1:0] IDX_ONE  = NUM_EVAL_LOG2'(1);

  // Symmetric limits so that negating a saturated score can never overflow.
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SUM,
    TAPER,
    SAT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic                           board_prev;
  logic                           board_rise;
  logic [8:0]                     phase_reg;
  logic [8:0]                     phase_clamped;
  logic [NUM_EVAL-1:0]            flags;
  logic signed [EVAL_WIDTH-1:0]   mg_lat [NUM_EVAL];
  logic signed [EVAL_WIDTH-1:0]   eg_lat [NUM_EVAL];
  logic signed [ACC_W-1:0]        acc_mg;
  logic signed [ACC_W-1:0]        acc_eg;
  logic [NUM_EVAL_LOG2-1:0]       idx;
  logic signed [PROD_W-1:0]       prod;

  logic signed [ACC_W-1:0]        mg_term;
  logic signed [ACC_W-1:0]        eg_term;
  logic signed [PROD_W-1:0]       acc_mg_x;
  logic signed [PROD_W-1:0]       acc_eg_x;
  logic signed [PROD_W-1:0]       ph_x;
  logic signed [PROD_W-1:0]       inv_x;
  logic signed [PROD_W-1:0]       prod_next;
  logic signed [PROD_W-1:0]       shifted;
  logic signed [PROD_W-1:0]       sat_val;

  assign board_rise    = board_valid & ~board_prev;
  assign phase_clamped = (phase > 9'd256) ? 9'd256 : phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (board_rise) next_state = COLLECT;
      COLLECT: if (&flags) next_state = SUM;
      SUM:     if (idx == IDX_LAST) next_state = TAPER;
      TAPER:   next_state = SAT;
      SAT:     next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
    if (clear_eval) begin
      next_state = IDLE;
    end
  end

  always_comb begin
    mg_term   = {{(ACC_W-EVAL_WIDTH){mg_lat[idx][EVAL_WIDTH-1]}}, mg_lat[idx]};
    eg_term   = {{(ACC_W-EVAL_WIDTH){eg_lat[idx][EVAL_WIDTH-1]}}, eg_lat[idx]};
    acc_mg_x  = {{(PROD_W-ACC_W){acc_mg[ACC_W-1]}}, acc_mg};
    acc_eg_x  = {{(PROD_W-ACC_W){acc_eg[ACC_W-1]}}, acc_eg};
    ph_x      = {{(PROD_W-9){1'b0}}, phase_reg};
    inv_x     = PROD_W'(256) - ph_x;
    prod_next = acc_mg_x * ph_x + acc_eg_x * inv_x;
    shifted   = prod >>> 8;
    sat_val   = shifted;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN;
    end
  end

  // The edge detector samples every cycle so a level held across a clear cannot retrigger.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board_prev <= 1'b0;
    end else begin
      board_prev <= board_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg  <= '0;
      flags      <= '0;
      acc_mg     <= '0;
      acc_eg     <= '0;
      idx        <= '0;
      prod       <= '0;
      eval       <= '0;
      eval_valid <= 1'b0;
      for (int i = 0; i < NUM_EVAL; i++) begin
        mg_lat[i] <= '0;
        eg_lat[i] <= '0;
      end
    end else if (clear_eval) begin
      flags      <= '0;
      eval_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (board_rise) begin
            phase_reg <= phase_clamped;
            flags     <= '0;
          end
        end
        COLLECT: begin
          // Each evaluator is captured once; later drops of its valid are ignored.
          for (int i = 0; i < NUM_EVAL; i++) begin
            if (eval_valid_in[i] && !flags[i]) begin
              mg_lat[i] <= eval_mg_in[i*EVAL_WIDTH +: EVAL_WIDTH];
              eg_lat[i] <= eval_eg_in[i*EVAL_WIDTH +: EVAL_WIDTH];
              flags[i]  <= 1'b1;
            end
          end
          if (&flags) begin
            acc_mg <= '0;
            acc_eg <= '0;
            idx    <= '0;
          end
        end
        SUM: begin
          acc_mg <= acc_mg + mg_term;
          acc_eg <= acc_eg + eg_term;
          idx    <= idx + IDX_ONE;
        end
        TAPER: begin
          prod <= prod_next;
        end
        SAT: begin
          eval       <= sat_val[EVAL_WIDTH-1:0];
          eval_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evaluate_taper.sv
// Self-checking bench for evaluate_taper: fixed vectors, randomized runs against an
// arithmetic reference, and hand-written clear/stagger/reset sequences.
module tb_evaluate_taper;

  localparam int W = 24;
  localparam int N = 4;
  localparam int L = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           board_valid;
  logic           clear_eval;
  logic [8:0]     phase;
  logic [N-1:0]   eval_valid_in;
  logic [N*W-1:0] eval_mg_in;
  logic [N*W-1:0] eval_eg_in;
  logic [W-1:0]   eval;
  logic           eval_valid;

  int tests_run    = 0;
  int tests_failed = 0;
  int cur_mg[N];
  int cur_eg[N];

  typedef struct {
    int    mg[N];
    int    eg[N];
    int    ph;
    int    exp_eval;
    string name;
  } vec_t;

  vec_t vecs[$];

  evaluate_taper #(
    .EVAL_WIDTH   (W),
    .NUM_EVAL     (N),
    .NUM_EVAL_LOG2(L)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .board_valid  (board_valid),
    .clear_eval   (clear_eval),
    .phase        (phase),
    .eval_valid_in(eval_valid_in),
    .eval_mg_in   (eval_mg_in),
    .eval_eg_in   (eval_eg_in),
    .eval         (eval),
    .eval_valid   (eval_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_output(input string name, input longint got, input longint exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Score from the rules: sum terms, weight by phase, floor-divide by 256, clamp.
  function automatic longint ref_eval(input int ph);
    longint p, sm, se, prod, t, lim;
    sm = 0;
    se = 0;
    p  = (ph > 256) ? 256 : ph;
    for (int i = 0; i < N; i++) begin
      sm += cur_mg[i];
      se += cur_eg[i];
    end
    prod = sm * p + se * (256 - p);
    t = prod / 256;
    if ((prod % 256 != 0) && (prod < 0)) t = t - 1;
    lim = (longint'(1) << (W - 1)) - 1;
    if (t > lim) t = lim;
    if (t < -lim) t = -lim;
    return t;
  endfunction

  task automatic load_buses();
    for (int i = 0; i < N; i++) begin
      eval_mg_in[i*W +: W] = cur_mg[i][W-1:0];
      eval_eg_in[i*W +: W] = cur_eg[i][W-1:0];
    end
  endtask

  task automatic set_plan_terms();
    cur_mg[0] = 100; cur_mg[1] = 200; cur_mg[2] = -50; cur_mg[3] = 0;
    cur_eg[0] = 10;  cur_eg[1] = 20;  cur_eg[2] = 30;  cur_eg[3] = 40;
  endtask

  task automatic add_vec(input int m0, input int m1, input int m2, input int m3,
                         input int e0, input int e1, input int e2, input int e3,
                         input int ph, input int ex, input string name);
    vec_t v;
    v.mg[0] = m0; v.mg[1] = m1; v.mg[2] = m2; v.mg[3] = m3;
    v.eg[0] = e0; v.eg[1] = e1; v.eg[2] = e2; v.eg[3] = e3;
    v.ph = ph;
    v.exp_eval = ex;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (eval_valid) lat = k;
    end
  endtask

  // All evaluators valid together, so the capture edge is the first COLLECT edge.
  task automatic apply_stimulus(input int ph, input longint exp_eval, input string name);
    int lat;
    @(negedge clk);
    load_buses();
    phase         = ph[8:0];
    eval_valid_in = '1;
    board_valid   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wait_valid(lat);
    check_output({name, "_latency"}, lat, 7);
    check_output(name, longint'($signed(eval)), exp_eval);
  endtask

  task automatic retire();
    @(negedge clk);
    clear_eval    = 1'b1;
    board_valid   = 1'b0;
    eval_valid_in = '0;
    @(negedge clk);
    clear_eval = 1'b0;
    check_output("clear_drops_valid", eval_valid, 0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    logic [31:0] rnd;

    reset         = 1'b0;
    board_valid   = 1'b0;
    clear_eval    = 1'b0;
    phase         = '0;
    eval_valid_in = '0;
    eval_mg_in    = '0;
    eval_eg_in    = '0;
    repeat (3) @(negedge clk);
    check_output("reset_eval", longint'($signed(eval)), 0);
    check_output("reset_valid", eval_valid, 0);
    reset = 1'b1;
    @(negedge clk);

    add_vec(100, 200, -50, 0, 10, 20, 30, 40, 256, 250, "plan_ph256");
    add_vec(100, 200, -50, 0, 10, 20, 30, 40, 0, 100, "plan_ph0");
    add_vec(100, 200, -50, 0, 10, 20, 30, 40, 128, 175, "plan_ph128");
    add_vec(100, 200, -50, 0, 10, 20, 30, 40, 300, 250, "phase_clamp300");
    add_vec(100, 200, -50, 0, 10, 20, 30, 40, 511, 250, "phase_clamp511");
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, 128, 0, "round_pos");
    add_vec(-1, 0, 0, 0, 0, 0, 0, 0, 128, -1, "round_neg");
    add_vec(8388607, 8388607, 8388607, 8388607, 0, 0, 0, 0, 256, 8388607, "sat_pos");
    add_vec(-8388608, -8388608, -8388608, -8388608, 0, 0, 0, 0, 256, -8388607, "sat_neg");
    add_vec(0, 0, 0, 0, -8388608, -8388608, 0, 0, 0, -8388607, "sat_neg_eg");

    foreach (vecs[v]) begin
      for (int i = 0; i < N; i++) begin
        cur_mg[i] = vecs[v].mg[i];
        cur_eg[i] = vecs[v].eg[i];
      end
      apply_stimulus(vecs[v].ph, vecs[v].exp_eval, vecs[v].name);
      retire();
    end

    for (int r = 0; r < 30; r++) begin
      int ph;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          cur_mg[i] = int'($urandom_range(0, 4000)) - 2000;
          cur_eg[i] = int'($urandom_range(0, 4000)) - 2000;
        end else begin
          rnd = $urandom;
          cur_mg[i] = int'($signed(rnd[W-1:0]));
          rnd = $urandom;
          cur_eg[i] = int'($signed(rnd[W-1:0]));
        end
      end
      ph = int'($urandom_range(0, 511));
      apply_stimulus(ph, ref_eval(ph), "random");
      retire();
    end

    // DONE ignores further board_valid edges and holds the score.
    set_plan_terms();
    apply_stimulus(256, 250, "done_base");
    @(negedge clk);
    board_valid = 1'b0;
    @(negedge clk);
    board_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_output("done_hold_valid", eval_valid, 1);
    check_output("done_hold_eval", longint'($signed(eval)), 250);
    retire();

    // Evaluator 3 arrives late; evaluator 0 drops valid and its bus turns to garbage.
    set_plan_terms();
    load_buses();
    @(negedge clk);
    phase         = 9'd128;
    eval_valid_in = 4'b0111;
    board_valid   = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    repeat (3) @(negedge clk);
    eval_valid_in[0]  = 1'b0;
    eval_mg_in[0 +: W] = 24'h123456;
    eval_eg_in[0 +: W] = 24'hABCDEF;
    repeat (7) begin
      @(negedge clk);
      if (eval_valid) seen = 1'b1;
    end
    eval_valid_in[3] = 1'b1;
    @(posedge clk);
    wait_valid(lat);
    check_output("stagger_early_valid", seen, 0);
    check_output("stagger_latency", lat, 7);
    check_output("stagger_eval", longint'($signed(eval)), 175);
    retire();

    // Clear during SUM: no result, then a fresh edge evaluates normally.
    set_plan_terms();
    load_buses();
    @(negedge clk);
    phase         = 9'd256;
    eval_valid_in = '1;
    board_valid   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_eval  = 1'b1;
    board_valid = 1'b0;
    @(negedge clk);
    clear_eval = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (eval_valid) seen = 1'b1;
    end
    check_output("clear_in_sum_valid", seen, 0);
    apply_stimulus(0, 100, "after_clear");
    retire();

    // Clear and a board_valid rising edge together: the edge is lost.
    @(negedge clk);
    phase         = 9'd256;
    eval_valid_in = '1;
    clear_eval    = 1'b1;
    board_valid   = 1'b1;
    @(negedge clk);
    clear_eval = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (eval_valid) seen = 1'b1;
    end
    check_output("clear_beats_edge", seen, 0);
    board_valid = 1'b0;
    @(negedge clk);
    apply_stimulus(128, 175, "after_clear_edge");
    retire();

    // Async reset while in TAPER; eval holds 175 from the previous run beforehand.
    @(negedge clk);
    phase         = 9'd256;
    eval_valid_in = '1;
    board_valid   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    reset       = 1'b0;
    board_valid = 1'b0;
    #1;
    check_output("async_reset_eval", longint'($signed(eval)), 0);
    check_output("async_reset_valid", eval_valid, 0);
    @(negedge clk);
    reset         = 1'b1;
    eval_valid_in = '0;
    apply_stimulus(256, 250, "after_reset");
    retire();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
